missile_pool_ctrl: RTL and testbench
====================================

Name: missile_pool_ctrl

Overview:
Multi-slot missile manager for one tank. It holds NUM_MISSILES independent projectiles, each with its own fixed-point position, direction and per-slot collision input. New shots go to the lowest-index free slot, subject to a frame-based cooldown. Missiles retire on collision or when they leave the screen. It sits between the keyboard/tank logic and the per-missile drawing and collision blocks.

Parameters:
NUM_MISSILES, 4, number of missile slots (1..8)
COORD_W, 11, pixel coordinate width
FRAC_BITS, 6, fixed-point fraction bits (multiplier = 2^FRAC_BITS)
MOVEMENT_SPEED, 300, fixed-point units added per frame along the firing axis
HALF_TANK, 7, pixel offset from tank top-left to the spawn point, applied on both X and Y
COOLDOWN_FRAMES, 8, frames after an accepted shot during which further shots are rejected
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels

Ports:
clk  in  1  system clock
resetN  in  1  async active-low reset
startOfFrame  in  1  one-clk pulse per frame
fireKey  in  1  level from keyboard decoder
tankTopLeftX  in  COORD_W  tank position X
tankTopLeftY  in  COORD_W  tank position Y
tankDir  in  2  00 up, 01 right, 10 down, 11 left
collision  in  NUM_MISSILES  per-slot collision, bit i = slot i
missileX  out  NUM_MISSILES*COORD_W  slot i occupies bits [i*COORD_W +: COORD_W]
missileY  out  NUM_MISSILES*COORD_W  same packing as missileX
drawEn  out  NUM_MISSILES  slot i flying
activeCount  out  4  number of flying slots
fireAccepted  out  1  one-clk pulse when a shot is allocated

Behaviour:
- Interface: reset resetN, asynchronous, active-low; clock clk.
- Reset: all slots IDLE, drawEn=0, positions=0, missileX/Y=0, cooldown=0, activeCount=0, fireAccepted=0, fireKey edge register=0.
- Fire request: rising edge of fireKey, detected with a registered previous value. A key held high produces exactly one request.
- Accept condition: request AND cooldown==0 AND at least one slot is IDLE at the start of the cycle. Otherwise the request is dropped, not queued.
- On accept (same clk as the edge):
  - Lowest-index IDLE slot becomes FLYING and its drawEn=1 on the next clk.
  - Slot position = (tankTopLeft + HALF_TANK) << FRAC_BITS.
  - Slot velocity is latched from tankDir: +/-MOVEMENT_SPEED on one axis, 0 on the other. Velocity does not change while the slot is flying.
  - cooldown = COOLDOWN_FRAMES; fireAccepted pulses for 1 clk.
- Cooldown: decrements by 1 on each startOfFrame while nonzero. It saturates at 0.
- Slot state machine: IDLE -> FLYING on allocation. FLYING -> IDLE on collision[i] or on out-of-bounds.
- Position registers: signed, COORD_W+FRAC_BITS+1 bits.
- Movement: on startOfFrame, each FLYING slot computes next = pos + vel.
  - If next>>FRAC_BITS < 0, or X >= SCREEN_W, or Y >= SCREEN_H, the slot goes IDLE and drawEn clears.
  - Otherwise pos = next.
- Priority per slot: collision > movement. collision[i] on an IDLE slot is ignored.
- Same-clk collision on slot i and a new allocation: allocation uses only slots IDLE at the start of the cycle, so a slot freed in that clk is not reused until the next clk.
- Outputs:
  - missileX/Y = pos >> FRAC_BITS (arithmetic shift), registered, valid whenever drawEn=1.
  - An IDLE slot holds its last value.
- activeCount: registered popcount of drawEn.
- Reset asserted mid-flight clears all state immediately.

Optional Feature:
MISSILE_AUTOFIRE_EN:
- Defined: while fireKey is held high, a request is generated each time cooldown reaches 0. The rising edge still fires immediately.
- Undefined: edge-only firing as described in Behaviour.

Test Plan:
- Reset, tank (100,200), dir 01, fireKey rise -> fireAccepted pulse, drawEn=0001, missile0=(107,207). After 1 frame X=111 (6848+300=7148, >>6 = 111), Y=207.
- Hold fireKey high 20 frames (autofire off) -> exactly one shot; activeCount=1.
- Four shots spaced 9 frames apart, then a fifth -> slots 0..3 fill, drawEn=1111; fifth shot dropped, fireAccepted stays 0.
- Shot 3 frames after an accepted shot -> rejected by cooldown. Retry after frame 8 -> accepted into slot 1.
- Tank (0,10), dir 00 -> Y decreases ~4.69 px/frame. The slot retires on the frame where Y would go below 0; drawEn[0]=0, activeCount=0.
- collision[0] and a fire edge in the same clk with only slot 0 free -> slot 0 retires and the shot is dropped. A fire on the next cycle (after cooldown) allocates slot 0.

Source files
------------

// File: rtl/missile_pool_ctrl.sv
// missile_pool_ctrl: multi-slot missile manager for one tank.
// Each slot holds a signed fixed-point position and a latched velocity.
// New shots take the lowest-index slot that is IDLE at the start of the cycle,
// gated by a frame-based cooldown. Slots retire on collision or leaving the screen.
// Optional build macro: MISSILE_AUTOFIRE_EN (held fireKey re-fires whenever cooldown reaches 0).
module missile_pool_ctrl #(
  parameter int NUM_MISSILES    = 4,
  parameter int COORD_W         = 11,
  parameter int FRAC_BITS       = 6,
  parameter int MOVEMENT_SPEED  = 300,
  parameter int HALF_TANK       = 7,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic                            fireKey,
  input  logic [COORD_W-1:0]              tankTopLeftX,
  input  logic [COORD_W-1:0]              tankTopLeftY,
  input  logic [1:0]                      tankDir,
  input  logic [NUM_MISSILES-1:0]         collision,
  output logic [NUM_MISSILES*COORD_W-1:0] missileX,
  output logic [NUM_MISSILES*COORD_W-1:0] missileY,
  output logic [NUM_MISSILES-1:0]         drawEn,
  output logic [3:0]                      activeCount,
  output logic                            fireAccepted
);

  localparam int POS_W = COORD_W + FRAC_BITS + 1;
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic signed [POS_W-1:0] SPEED   = POS_W'(MOVEMENT_SPEED);
  localparam logic signed [POS_W:0]   X_LIM   = (POS_W+1)'(SCREEN_W * (2 ** FRAC_BITS));
  localparam logic signed [POS_W:0]   Y_LIM   = (POS_W+1)'(SCREEN_H * (2 ** FRAC_BITS));
  localparam logic [CD_W-1:0]         CD_INIT = CD_W'(COOLDOWN_FRAMES);

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  slot_state_t state      [NUM_MISSILES];
  slot_state_t state_next [NUM_MISSILES];

  logic signed [POS_W-1:0] pos_x  [NUM_MISSILES];
  logic signed [POS_W-1:0] pos_y  [NUM_MISSILES];
  logic signed [POS_W-1:0] vel_x  [NUM_MISSILES];
  logic signed [POS_W-1:0] vel_y  [NUM_MISSILES];
  logic signed [POS_W:0]   next_x [NUM_MISSILES];
  logic signed [POS_W:0]   next_y [NUM_MISSILES];
  logic [COORD_W-1:0]      out_x  [NUM_MISSILES];
  logic [COORD_W-1:0]      out_y  [NUM_MISSILES];

  logic [NUM_MISSILES-1:0] idle;
  logic [NUM_MISSILES-1:0] alloc_sel;
  logic [NUM_MISSILES-1:0] oob;
  logic [NUM_MISSILES-1:0] step;
  logic                    any_idle;
  logic                    fire_prev;
  logic                    fire_rise;
  logic                    fire_req;
  logic                    accept;
  logic [CD_W-1:0]         cooldown;
  logic [COORD_W:0]        spawn_x;
  logic [COORD_W:0]        spawn_y;
  logic signed [POS_W-1:0] spawn_vx;
  logic signed [POS_W-1:0] spawn_vy;
  logic [3:0]              count_next;

  // Fire request detection and lowest-index free-slot selection
  always_comb begin
    fire_rise = fireKey & ~fire_prev;
`ifdef MISSILE_AUTOFIRE_EN
    fire_req  = fire_rise | (fireKey & fire_prev);
`else
    fire_req  = fire_rise;
`endif
    idle      = '0;
    alloc_sel = '0;
    any_idle  = 1'b0;
    for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
      idle[i]      = (state[i] == IDLE);
      alloc_sel[i] = idle[i] & ~any_idle;
      any_idle     = any_idle | idle[i];
    end
    accept = fire_req & (cooldown == '0) & any_idle;
  end

  // Spawn point and velocity derived from the tank pose
  always_comb begin
    spawn_x  = {1'b0, tankTopLeftX} + (COORD_W+1)'(HALF_TANK);
    spawn_y  = {1'b0, tankTopLeftY} + (COORD_W+1)'(HALF_TANK);
    spawn_vx = '0;
    spawn_vy = '0;
    case (tankDir)
      2'b00:   spawn_vy = -SPEED;
      2'b01:   spawn_vx = SPEED;
      2'b10:   spawn_vy = SPEED;
      default: spawn_vx = -SPEED;
    endcase
  end

  // Per-slot next state: allocation, collision (priority), then frame movement
  always_comb begin
    count_next = '0;
    step       = '0;
    oob        = '0;
    for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
      // One extra bit so the bounds test cannot be fooled by wrap-around
      next_x[i] = {pos_x[i][POS_W-1], pos_x[i]} + {vel_x[i][POS_W-1], vel_x[i]};
      next_y[i] = {pos_y[i][POS_W-1], pos_y[i]} + {vel_y[i][POS_W-1], vel_y[i]};
      oob[i]    = next_x[i][POS_W] | next_y[i][POS_W] |
                  (next_x[i] >= X_LIM) | (next_y[i] >= Y_LIM);
      state_next[i] = state[i];
      if (state[i] == IDLE) begin
        if (accept && alloc_sel[i]) state_next[i] = FLYING;
      end else begin
        if (collision[i])                 state_next[i] = IDLE;
        else if (startOfFrame && oob[i])  state_next[i] = IDLE;
        else if (startOfFrame)            step[i] = 1'b1;
      end
      if (state_next[i] == FLYING) count_next = count_next + 4'd1;
    end
  end

  // Slot state registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_MISSILES; i++) state[i] <= IDLE;
    end else begin
      for (int unsigned i = 0; i < NUM_MISSILES; i++) state[i] <= state_next[i];
    end
  end

  // Slot position, velocity and pixel output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        out_x[i] <= '0;
        out_y[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
        if (accept && alloc_sel[i]) begin
          pos_x[i] <= {spawn_x, {FRAC_BITS{1'b0}}};
          pos_y[i] <= {spawn_y, {FRAC_BITS{1'b0}}};
          vel_x[i] <= spawn_vx;
          vel_y[i] <= spawn_vy;
          out_x[i] <= spawn_x[COORD_W-1:0];
          out_y[i] <= spawn_y[COORD_W-1:0];
        end else if (step[i]) begin
          pos_x[i] <= next_x[i][POS_W-1:0];
          pos_y[i] <= next_y[i][POS_W-1:0];
          out_x[i] <= next_x[i][FRAC_BITS +: COORD_W];
          out_y[i] <= next_y[i][FRAC_BITS +: COORD_W];
        end
      end
    end
  end

  // Fire edge register, cooldown counter, accept pulse and active count
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_prev    <= 1'b0;
      cooldown     <= '0;
      fireAccepted <= 1'b0;
      activeCount  <= '0;
    end else begin
      fire_prev    <= fireKey;
      fireAccepted <= accept;
      activeCount  <= count_next;
      if (accept)                             cooldown <= CD_INIT;
      else if (startOfFrame && cooldown != '0) cooldown <= cooldown - 1'b1;
    end
  end

  // Pack per-slot outputs
  always_comb begin
    missileX = '0;
    missileY = '0;
    drawEn   = '0;
    for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
      missileX[i*COORD_W +: COORD_W] = out_x[i];
      missileY[i*COORD_W +: COORD_W] = out_y[i];
      drawEn[i]                      = (state[i] == FLYING);
    end
  end

endmodule

// File: tb/tb_missile_pool_ctrl.sv
// Self-checking bench for missile_pool_ctrl (default parameters, autofire off).
module tb_missile_pool_ctrl;

  localparam int N  = 4;
  localparam int CW = 11;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            startOfFrame = 1'b0;
  logic            fireKey = 1'b0;
  logic [CW-1:0]   tx = '0;
  logic [CW-1:0]   ty = '0;
  logic [1:0]      dir = '0;
  logic [N-1:0]    collision = '0;
  logic [N*CW-1:0] missileX;
  logic [N*CW-1:0] missileY;
  logic [N-1:0]    drawEn;
  logic [3:0]      activeCount;
  logic            fireAccepted;

  typedef struct {
    bit acc;
    int slot;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pulses;

  missile_pool_ctrl #(
    .NUM_MISSILES(N),
    .COORD_W(CW)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .fireKey(fireKey),
    .tankTopLeftX(tx),
    .tankTopLeftY(ty),
    .tankDir(dir),
    .collision(collision),
    .missileX(missileX),
    .missileY(missileY),
    .drawEn(drawEn),
    .activeCount(activeCount),
    .fireAccepted(fireAccepted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot_x(input int s);
    return 32'(missileX[s*CW +: CW]);
  endfunction

  function automatic logic [31:0] slot_y(input int s);
    return 32'(missileY[s*CW +: CW]);
  endfunction

  // Pixel coordinate after n frames from a spawn at base+7, moving sign*300 per frame
  function automatic int mdl(input int base, input int n, input int sign);
    return ((base + 7) * 64 + sign * n * 300) >>> 6;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    for (int k = 0; k < n; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic reset_dut();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  // Drive one fire edge; expectation queued at drive time, compared when the DUT responds
  task automatic fire(input bit acc, input int slot, input int x, input int y);
    exp_t e;
    e.acc = acc; e.slot = slot; e.x = x; e.y = y;
    sb.push_back(e);
    fireKey = 1'b1;
    tick();
    e = sb.pop_front();
    check("fire_accepted", 32'(fireAccepted), 32'(e.acc));
    if (e.acc) begin
      check("fire_draw_en", 32'(drawEn[e.slot]), 32'd1);
      check("fire_spawn_x", slot_x(e.slot), 32'(e.x));
      check("fire_spawn_y", slot_y(e.slot), 32'(e.y));
    end
    fireKey = 1'b0;
    tick();
    check("fire_pulse_end", 32'(fireAccepted), 32'd0);
  endtask

  initial begin
    // Reset state
    resetN = 1'b0;
    tick();
    tick();
    check("rst_draw_en", 32'(drawEn), 32'd0);
    check("rst_count", 32'(activeCount), 32'd0);
    check("rst_accepted", 32'(fireAccepted), 32'd0);
    check("rst_x", 32'(missileX), 32'd0);
    check("rst_y", 32'(missileY), 32'd0);
    resetN = 1'b1;
    tick();

    // First shot to the right, then one frame of movement
    tx = 11'd100; ty = 11'd200; dir = 2'b01;
    fire(1'b1, 0, 107, 207);
    check("shot1_draw_en", 32'(drawEn), 32'b0001);
    frame(1);
    check("move1_x", slot_x(0), 32'(mdl(100, 1, 1)));
    check("move1_y", slot_y(0), 32'd207);
    check("move1_count", 32'(activeCount), 32'd1);

    // Asynchronous reset while a missile is flying
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("async_rst_draw_en", 32'(drawEn), 32'd0);
    check("async_rst_x", slot_x(0), 32'd0);
    tick();
    resetN = 1'b1;
    tick();

    // Held key for 20 frames produces a single shot
    pulses = 0;
    fireKey = 1'b1;
    for (int k = 0; k < 20; k++) begin
      startOfFrame = 1'b1;
      tick();
      pulses += int'(fireAccepted);
      startOfFrame = 1'b0;
      tick();
      pulses += int'(fireAccepted);
    end
    fireKey = 1'b0;
    tick();
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_count", 32'(activeCount), 32'd1);
    check("hold_x", slot_x(0), 32'(mdl(100, 19, 1)));

    // Fill all four slots, fifth shot dropped
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      fire(1'b1, k, 107, 207);
      frame(9);
    end
    check("full_draw_en", 32'(drawEn), 32'b1111);
    check("full_count", 32'(activeCount), 32'd4);
    check("full_slot0_x", slot_x(0), 32'(mdl(100, 36, 1)));
    check("full_slot3_x", slot_x(3), 32'(mdl(100, 9, 1)));
    fire(1'b0, 0, 0, 0);
    check("full_after_drop", 32'(drawEn), 32'b1111);

    // Collision and fire edge in the same clk: slot 0 retires, shot dropped
    collision = 4'b0001;
    fireKey = 1'b1;
    tick();
    collision = '0;
    check("coll_fire_dropped", 32'(fireAccepted), 32'd0);
    check("coll_draw_en", 32'(drawEn), 32'b1110);
    check("coll_count", 32'(activeCount), 32'd3);
    fireKey = 1'b0;
    tick();
    fire(1'b1, 0, 107, 207);
    check("coll_refill", 32'(drawEn), 32'b1111);

    // Cooldown rejection and retry after the eighth frame
    reset_dut();
    fire(1'b1, 0, 107, 207);
    frame(3);
    fire(1'b0, 0, 0, 0);
    check("cd_draw_en", 32'(drawEn), 32'b0001);
    frame(5);
    fire(1'b1, 1, 107, 207);
    check("cd_retry_draw_en", 32'(drawEn), 32'b0011);
    check("cd_retry_count", 32'(activeCount), 32'd2);

    // Upward shot retires when Y would go below 0
    reset_dut();
    tx = 11'd0; ty = 11'd10; dir = 2'b00;
    fire(1'b1, 0, 7, 17);
    for (int k = 1; k <= 3; k++) begin
      frame(1);
      check("up_y", slot_y(0), 32'(mdl(10, k, -1)));
      check("up_draw_en", 32'(drawEn[0]), 32'd1);
    end
    frame(1);
    check("up_retired", 32'(drawEn[0]), 32'd0);
    check("up_count", 32'(activeCount), 32'd0);
    check("up_hold_y", slot_y(0), 32'd2);
    check("up_hold_x", slot_x(0), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
